// File: rtl/spi_bus_bridge_if.sv
// Memory-bus handshake between the SPI bridge (master) and the SoC bus (slave).
interface spi_bus_bridge_if;
  logic        bus_req;
  logic        bus_we;
  logic [3:0]  bus_be;
  logic [31:0] bus_addr;
  logic [31:0] bus_wdata;
  logic        bus_gnt;
  logic        bus_rvalid;
  logic [31:0] bus_rdata;
  logic        bus_err;

  modport master (
    output bus_req, bus_we, bus_be, bus_addr, bus_wdata,
    input  bus_gnt, bus_rvalid, bus_rdata, bus_err
  );

  modport slave (
    input  bus_req, bus_we, bus_be, bus_addr, bus_wdata,
    output bus_gnt, bus_rvalid, bus_rdata, bus_err
  );
endinterface

// File: rtl/spi_bus_bridge.sv
// Turns each new SPI command frame into one 32-bit bus access in the CLK domain
// and returns read data or error status on REG_DOUT for the next read-out frame.
module spi_bus_bridge #(
  parameter logic [31:0] BASE_ADDR      = 32'h0000_0000,
  parameter int          TIMEOUT_CYCLES = 255,
  parameter logic [31:0] ERR_DATA       = 32'hDEAD_BEEF
) (
  input  logic                     CLK,
  input  logic                     reset,
  input  logic                     SS,
  input  logic [31:0]              REG_ADDR,
  input  logic [31:0]              REG_DIN,
  output logic [31:0]              REG_DOUT,
  spi_bus_bridge_if.master         bus,
  output logic                     busy,
  output logic [7:0]               status
);

  typedef enum logic [2:0] {IDLE, CAPTURE, REQ, WAIT_RSP, DONE} state_t;

  localparam logic [7:0] TMO_LAST = 8'(TIMEOUT_CYCLES - 1);

  state_t      state;
  logic        ss_s1, ss_s2, ss_s2_d;
  logic        ss_rise;
  logic        pending;
  logic [31:0] cmd_addr;
  logic [31:0] cmd_data;
  logic [5:0]  last_tag;
  logic [7:0]  tmo_cnt;
  logic        tmo_hit;
  logic        err_f, tmo_f;
  logic [31:0] rsp_dout;

  wire        cmd_we    = cmd_addr[31];
  wire        cmd_valid = cmd_addr[30];
  wire [5:0]  cmd_tag   = cmd_addr[29:24];

  assign bus.bus_be = 4'hF;
  assign ss_rise    = ss_s2 & ~ss_s2_d;
  assign tmo_hit    = (tmo_cnt == TMO_LAST);

  // NOTE: every variable assigned in always_comb gets a value on every path, or a latch is inferred.
  always_comb begin
    rsp_dout = REG_DOUT;
    if (bus.bus_err)     rsp_dout = ERR_DATA;
    else if (!bus.bus_we) rsp_dout = bus.bus_rdata;
  end

  // NOTE: synchronizer flops reset to 1 (SS idle level) so reset release cannot fake an SS rise.
  always_ff @(posedge CLK or negedge reset) begin
    if (!reset) begin
      ss_s1   <= 1'b1;
      ss_s2   <= 1'b1;
      ss_s2_d <= 1'b1;
    end else begin
      ss_s1   <= SS;
      ss_s2   <= ss_s1;
      ss_s2_d <= ss_s2;
    end
  end

  // NOTE: non-blocking assignments throughout, so every flop samples pre-edge values.
  always_ff @(posedge CLK or negedge reset) begin
    if (!reset) begin
      state         <= IDLE;
      pending       <= 1'b0;
      cmd_addr      <= '0;
      cmd_data      <= '0;
      last_tag      <= 6'h3F;
      tmo_cnt       <= '0;
      err_f         <= 1'b0;
      tmo_f         <= 1'b0;
      REG_DOUT      <= '0;
      status        <= '0;
      busy          <= 1'b0;
      bus.bus_req   <= 1'b0;
      bus.bus_we    <= 1'b0;
      bus.bus_addr  <= '0;
      bus.bus_wdata <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (pending) begin
            cmd_addr <= REG_ADDR;
            cmd_data <= REG_DIN;
            pending  <= 1'b0;
            busy     <= 1'b1;
            state    <= CAPTURE;
          end
        end
        CAPTURE: begin
          if (cmd_valid && (cmd_tag != last_tag)) begin
            bus.bus_addr  <= BASE_ADDR | {6'b0, cmd_addr[23:0], 2'b00};
            bus.bus_we    <= cmd_we;
            bus.bus_wdata <= cmd_we ? cmd_data : 32'h0;
            bus.bus_req   <= 1'b1;
            tmo_cnt       <= '0;
            err_f         <= 1'b0;
            tmo_f         <= 1'b0;
            state         <= REQ;
          end else begin
            busy  <= 1'b0;
            state <= IDLE;
          end
        end
        REQ: begin
          tmo_cnt <= tmo_cnt + 8'd1;
          if (bus.bus_gnt && bus.bus_rvalid) begin
            bus.bus_req <= 1'b0;
            REG_DOUT    <= rsp_dout;
            err_f       <= bus.bus_err;
            state       <= DONE;
          end else if (tmo_hit) begin
            bus.bus_req <= 1'b0;
            REG_DOUT    <= ERR_DATA;
            tmo_f       <= 1'b1;
            state       <= DONE;
          end else if (bus.bus_gnt) begin
            bus.bus_req <= 1'b0;
            state       <= WAIT_RSP;
          end
        end
        WAIT_RSP: begin
          tmo_cnt <= tmo_cnt + 8'd1;
          // A response in the timeout cycle still counts as a normal completion.
          if (bus.bus_rvalid) begin
            REG_DOUT <= rsp_dout;
            err_f    <= bus.bus_err;
            state    <= DONE;
          end else if (tmo_hit) begin
            REG_DOUT <= ERR_DATA;
            tmo_f    <= 1'b1;
            state    <= DONE;
          end
        end
        DONE: begin
          last_tag <= cmd_tag;
          status   <= {err_f, tmo_f, cmd_tag};
          busy     <= 1'b0;
          state    <= IDLE;
        end
        default: begin
          busy  <= 1'b0;
          state <= IDLE;
        end
      endcase

      // Placed last so a new SS rise beats the clear on IDLE->CAPTURE.
      if (ss_rise) pending <= 1'b1;
    end
  end

endmodule

// File: doc/spi_bus_bridge.md
Name: spi_bus_bridge

Overview:
- Consumes the SPI slave's frame registers (REG_ADDR, REG_DIN) and runs one 32-bit memory-bus access per new command in the system clock domain.
- Returns read data or error status on REG_DOUT for the next SPI read-out frame.
- Sits directly downstream of the SPI slave and is the SoC's SPI debug/bring-up master.

Parameters:
- BASE_ADDR, 32'h00000000, OR-ed onto the generated bus address.
- TIMEOUT_CYCLES, 255, CLK cycles allowed from bus_req rise to bus_rvalid before abort (8-bit counter, 1..255).
- ERR_DATA, 32'hDEADBEEF, value loaded into REG_DOUT on a bus error or timeout.

Ports:
- CLK  input  1  system clock; all logic on posedge.
- reset  input  1  asynchronous, active-low reset (0 = reset).
- SS  input  1  raw SPI chip select from pad, active low; asynchronous to CLK.
- REG_ADDR  input  32  command word: [31]=WE, [30]=VALID, [29:24]=TAG, [23:0]=word address.
- REG_DIN  input  32  write data.
- REG_DOUT  output  32  read-back data to the SPI slave.
- bus_req  output  1  request.
- bus_we  output  1  1 = write.
- bus_be  output  4  byte enables; always 4'hF.
- bus_addr  output  32  BASE_ADDR | {6'b0, REG_ADDR[23:0], 2'b00}.
- bus_wdata  output  32  write data.
- bus_gnt  input  1  request accepted.
- bus_rvalid  input  1  response valid; one cycle.
- bus_rdata  input  32  read data.
- bus_err  input  1  error, qualified by bus_rvalid.
- busy  output  1  high in any state other than IDLE.
- status  output  8  {err, timeout, TAG[5:0]} of the last completed access.

Behaviour:
- Reset (asynchronous, any state):
  - State goes to IDLE.
  - SS synchronizer flops reset to 1.
  - pending=0, last_tag=6'h3F, REG_DOUT=0, status=0, bus_req=0, bus_we=0, bus_addr=0, bus_wdata=0, busy=0.
- SS crossing:
  - 2-flop synchronizer s1→s2, then an s2_d delay flop.
  - ss_rise = s2 & ~s2_d (one-cycle pulse).
  - ss_rise sets pending in any state. pending is cleared only on the IDLE→CAPTURE transition. If both happen in the same cycle, the set wins.
  - REG_ADDR/REG_DIN are quasi-static: they change only at SS rise and are stable before ss_rise is seen. No further synchronization is applied.
- States: IDLE, CAPTURE, REQ, WAIT_RSP, DONE.
- IDLE:
  - pending=1 → CAPTURE; latch cmd_addr=REG_ADDR and cmd_data=REG_DIN; clear pending.
- CAPTURE (1 cycle):
  - Execute if cmd VALID=1 and TAG≠last_tag: → REQ, driving bus_addr, bus_we=WE, bus_wdata (cmd_data when writing, else 0), bus_req=1, and clear the timeout counter.
  - Otherwise → IDLE with no bus activity. REG_DOUT, status and last_tag are unchanged.
- REQ:
  - bus_req held high and address/data held stable until bus_gnt.
  - bus_gnt=1 → drop bus_req next cycle, → WAIT_RSP.
  - A bus_rvalid arriving in the same cycle as bus_gnt is accepted and goes straight to DONE.
- WAIT_RSP:
  - bus_rvalid=1 → DONE.
  - Read with no bus_err: REG_DOUT=bus_rdata.
  - bus_err=1 (read or write): REG_DOUT=ERR_DATA, status.err=1.
  - Write with no bus_err: REG_DOUT is unchanged.
- Timeout:
  - The counter increments every cycle in REQ and WAIT_RSP.
  - Reaching TIMEOUT_CYCLES → drop bus_req, REG_DOUT=ERR_DATA, status.timeout=1, → DONE.
  - If timeout and rvalid fall in the same cycle, rvalid wins.
- DONE (1 cycle):
  - last_tag=TAG; status={err, timeout, TAG}, with err/timeout cleared for a successful access; → IDLE.
  - Late bus_rvalid pulses after a timeout are ignored.
- SS rising while busy:
  - Recorded in pending and serviced on return to IDLE.
  - Multiple rises while busy collapse into one; the REG_ADDR/REG_DIN values present at CAPTURE are used.
- Latency:
  - SS rise → bus_req high within 6 CLK cycles: 2 sync + 1 edge + IDLE + CAPTURE + REQ.
  - Read completion → REG_DOUT valid 1 cycle after bus_rvalid.

Test Plan:
- Write: REG_ADDR=32'hC1000010, REG_DIN=32'hA5A5A5A5, SS pulse → one bus_req with bus_we=1, bus_addr=32'h00000040, bus_wdata=32'hA5A5A5A5; status=8'h01.
- Read: REG_ADDR=32'h42000010, bus_rdata=32'h12345678 one cycle after bus_gnt → REG_DOUT=32'h12345678, status=8'h02, busy back to 0.
- Repeat tag / invalid: a second SS pulse with the same REG_ADDR (TAG 2), and one with VALID=0 → no bus_req, REG_DOUT unchanged.
- Timeout: read with bus_gnt never asserted, TIMEOUT_CYCLES=16 → bus_req drops after 16 cycles, REG_DOUT=32'hDEADBEEF, status[6]=1; a later bus_rvalid is ignored.
- Error and busy overlap:
  - Read answered with bus_err=1 → REG_DOUT=ERR_DATA, status[7]=1.
  - During it, 3 SS pulses with a new TAG → exactly one further access after DONE.
- Reset mid-access: reset low while in WAIT_RSP → bus_req=0, REG_DOUT=0, status=0, busy=0 immediately; after release, a TAG=6'h3F command is skipped and TAG=0 executes.
